// File: rtl/ahbl_req_adapter_if.sv
// Request/response stream and AHB-Lite master bus bundle for ahbl_req_adapter.
// The master modport is the adapter side; slave is the upstream client plus AHB slave side.
interface ahbl_req_adapter_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [W_ADDR-1:0] req_addr;
  logic              req_write;
  logic [2:0]        req_size;
  logic [W_DATA-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [W_DATA-1:0] resp_rdata;
  logic              ahbl_hready;
  logic              ahbl_hresp;
  logic [W_ADDR-1:0] ahbl_haddr;
  logic [1:0]        ahbl_htrans;
  logic              ahbl_hwrite;
  logic [2:0]        ahbl_hsize;
  logic [2:0]        ahbl_hburst;
  logic [3:0]        ahbl_hprot;
  logic              ahbl_hmastlock;
  logic [W_DATA-1:0] ahbl_hwdata;
  logic [W_DATA-1:0] ahbl_hrdata;

  modport master (
    input  req_valid, req_addr, req_write, req_size, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
    input  ahbl_hready, ahbl_hresp, ahbl_hrdata,
    output ahbl_haddr, ahbl_htrans, ahbl_hwrite, ahbl_hsize, ahbl_hburst,
           ahbl_hprot, ahbl_hmastlock, ahbl_hwdata
  );

  modport slave (
    output req_valid, req_addr, req_write, req_size, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    output ahbl_hready, ahbl_hresp, ahbl_hrdata,
    input  ahbl_haddr, ahbl_htrans, ahbl_hwrite, ahbl_hsize, ahbl_hburst,
           ahbl_hprot, ahbl_hmastlock, ahbl_hwdata
  );
endinterface

// File: rtl/ahbl_req_adapter.sv
// Valid/ready request stream to pipelined AHB-Lite SINGLE NSEQ master.
// Two slots: address phase (aph) and data phase (dph); all bus outputs come from them.
module ahbl_req_adapter #(
  parameter int         W_ADDR = 32,
  parameter int         W_DATA = 32,
  parameter logic [3:0] HPROT  = 4'b0011
) (
  input logic                clk,
  input logic                rst_n,
  ahbl_req_adapter_if.master bus
);
  localparam logic [1:0]  HTRANS_IDLE = 2'b00;
  localparam logic [1:0]  HTRANS_NSEQ = 2'b10;
  localparam logic [31:0] W_DATA_U    = W_DATA;

  typedef struct packed {
    logic              vld;
    logic              fault;
    logic              write;
    logic [W_ADDR-1:0] addr;
    logic [2:0]        size;
    logic [W_DATA-1:0] wdata;
  } slot_t;

  slot_t aph, dph, req_slot;
  logic  accept, misalign, too_big;
  logic [W_ADDR-1:0] align_mask;

  assign bus.req_ready = !aph.vld || bus.ahbl_hready;
  assign accept        = bus.req_valid && bus.req_ready;

  // Faulted requests still take a slot so responses stay in order; they just never hit the bus.
  assign align_mask = (W_ADDR'(1) << bus.req_size) - W_ADDR'(1);
  assign misalign   = |(bus.req_addr & align_mask);
  assign too_big    = (32'd8 << bus.req_size) > W_DATA_U;

  always_comb begin
    req_slot       = '0;
    req_slot.vld   = 1'b1;
    req_slot.fault = misalign || too_big;
    req_slot.write = bus.req_write;
    req_slot.addr  = bus.req_addr;
    req_slot.size  = bus.req_size;
    req_slot.wdata = bus.req_wdata;
  end

  // With hready low the pipe holds, except that an empty address slot may still be filled:
  // IDLE -> NSEQ during a wait state is legal, and it then holds until hready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aph <= '0;
      dph <= '0;
    end else if (bus.ahbl_hready) begin
      dph <= aph;
      aph <= accept ? req_slot : '0;
    end else if (!aph.vld && accept) begin
      aph <= req_slot;
    end
  end

  assign bus.ahbl_htrans    = (aph.vld && !aph.fault) ? HTRANS_NSEQ : HTRANS_IDLE;
  assign bus.ahbl_haddr     = aph.addr;
  assign bus.ahbl_hwrite    = aph.write;
  assign bus.ahbl_hsize     = aph.size;
  assign bus.ahbl_hburst    = 3'b000;
  assign bus.ahbl_hprot     = HPROT;
  assign bus.ahbl_hmastlock = 1'b0;
  assign bus.ahbl_hwdata    = (dph.vld && dph.write && !dph.fault) ? dph.wdata : '0;

  assign bus.resp_valid = dph.vld && bus.ahbl_hready;
  assign bus.resp_err   = dph.fault || bus.ahbl_hresp;
  assign bus.resp_rdata = (dph.vld && !dph.write && !dph.fault) ? bus.ahbl_hrdata : '0;
endmodule
